// File: rtl/led_shift_driver.sv
// Serial driver for chained 74HC595-class LED shift registers: takes a frame
// over valid/ready, shifts it out on SerClk/SerData, then strobes Latch.
module led_shift_driver #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned LATCH_CYC    = 2,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          LATCH_LOW    = 1'b1,
  parameter bit          AUTO_REFRESH = 1'b0
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_Valid,
  output logic              o_Ready,
  output logic              o_SerClk,
  output logic              o_SerData,
  output logic              o_Latch,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int unsigned CNT_MAX = (CLK_DIV > LATCH_CYC) ? CLK_DIV : LATCH_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W);
  localparam int unsigned OUT_IDX = MSB_FIRST ? DATA_W - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFT_LO = 2'd1,
    S_SHIFT_HI = 2'd2,
    S_LATCH    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                last_v_q, last_v_d;
  logic                take_frame;
  logic [DATA_W-1:0]   shift_next;

  logic ready_q, ready_d;
  logic ser_clk_q, ser_clk_d;
  logic ser_data_q, ser_data_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // State and datapath registers
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      last_q     <= '0;
      last_v_q   <= 1'b0;
      ready_q    <= 1'b1;
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
      latch_q    <= LATCH_LOW;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      last_q     <= last_d;
      last_v_q   <= last_v_d;
      ready_q    <= ready_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state, counters, pending buffer and frame load
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    last_d     = last_q;
    last_v_d   = last_v_q;
    take_frame = 1'b0;

    if (MSB_FIRST) shift_next = {shift_q[DATA_W-2:0], 1'b0};
    else           shift_next = {1'b0, shift_q[DATA_W-1:1]};

    if (i_Valid && ready_q) begin
      pend_d   = i_Data;
      pend_v_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        take_frame = 1'b1;
      end
      S_SHIFT_LO: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = S_SHIFT_HI;
          cnt_d   = '0;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_SHIFT_LO;
            shift_d = shift_next;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      S_LATCH: begin
        if (cnt_q == CNT_W'(LATCH_CYC - 1)) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          take_frame = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Same decision from IDLE and the final latch cycle; pending beats refresh
    if (take_frame) begin
      if (pend_v_q) begin
        shift_d  = pend_q;
        last_d   = pend_q;
        last_v_d = 1'b1;
        pend_v_d = 1'b0;
        bit_d    = '0;
        cnt_d    = '0;
        state_d  = S_SHIFT_LO;
      end else if (AUTO_REFRESH && last_v_q) begin
        shift_d = last_q;
        bit_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT_LO;
      end
    end
  end

  // Output values derived from the next state so they align with state_q
  always_comb begin
    ser_clk_d  = (state_d == S_SHIFT_HI);
    ser_data_d = ser_data_q;
    if (state_d == S_SHIFT_LO && state_q != S_SHIFT_LO) begin
      ser_data_d = shift_d[OUT_IDX];
    end else if (state_d == S_LATCH || state_d == S_IDLE) begin
      ser_data_d = 1'b0;
    end
    latch_d = (state_d == S_LATCH) ^ LATCH_LOW;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_LATCH) && (cnt_d == CNT_W'(LATCH_CYC - 1));
    ready_d = !pend_v_d;
  end

  assign o_Ready   = ready_q;
  assign o_SerClk  = ser_clk_q;
  assign o_SerData = ser_data_q;
  assign o_Latch   = latch_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;

endmodule
